// File: rtl/dense_layer_seq.sv
// Frame sequencer for one fixed-point dense layer: issues NUM_CYC buffer read beats,
// aligns vld_in to the buffer latency, waits for the result and hands it downstream.
// Optional WAIT watchdog: define DENSE_SEQ_TIMEOUT_EN.
module dense_layer_seq #(
    parameter int NUM_CYC = 512,
    parameter int MEM_LAT = 1,
    parameter int TIMEOUT = 64,
    parameter int AW      = (NUM_CYC > 1) ? $clog2(NUM_CYC) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          start_rdy,
    input  logic          src_vld,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          dl_vld_in,
    output logic          dl_rst,
    input  logic          dl_vld_out,
    output logic          cap_en,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy,
    output logic [1:0]    err,
    output logic [15:0]   frames_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_FLUSH,
        S_WAIT,
        S_HOLD
    } state_t;

    // A zero-latency buffer still spends one cycle in FLUSH.
    localparam int FLUSH_CYC = (MEM_LAT > 0) ? MEM_LAT : 1;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] beat;
    logic [2:0]    flush_cnt;
    logic          last_beat;
    logic          flush_done;
    logic          timeout_hit;
    logic          abort;

    assign last_beat  = (beat == AW'(NUM_CYC - 1));
    assign flush_done = (flush_cnt == 3'(FLUSH_CYC - 1));

`ifdef DENSE_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == S_WAIT) && (wait_cnt == TW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        cap_en    = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // NOTE: a read in the reset cycle is discarded, so the strobe is gated by rst.
                rd_en = src_vld && !rst;
                if (rd_en && last_beat) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_done) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dl_vld_out) begin
                    cap_en    = !rst;
                    state_nxt = S_HOLD;
                end else if (timeout_hit) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            beat        <= '0;
            flush_cnt   <= '0;
            err         <= '0;
            frames_done <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_IDLE && start) begin
                beat <= '0;
            end else if (rd_en) begin
                beat <= last_beat ? '0 : beat + 1'b1;
            end

            flush_cnt <= (state == S_FLUSH) ? flush_cnt + 1'b1 : '0;

            if (dl_vld_out && state != S_WAIT) begin
                err[0] <= 1'b1;
            end
            if (abort) begin
                err[1] <= 1'b1;
            end

            if (state == S_HOLD && res_ready) begin
                frames_done <= frames_done + 1'b1;
            end
        end
    end

    generate
        if (MEM_LAT == 0) begin : g_no_lat
            assign dl_vld_in = rd_en;
        end else begin : g_lat
            logic [MEM_LAT-1:0] vld_pipe;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[0] <= rd_en;
                    for (int i = 1; i < MEM_LAT; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                    end
                end
            end

            assign dl_vld_in = vld_pipe[MEM_LAT-1];
        end
    endgenerate

    // The layer's own beat counter is cleared on abort so it restarts in step with beat.
    assign dl_rst    = rst | abort;
    assign rd_addr   = beat;
    assign start_rdy = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_HOLD);

endmodule

// File: doc/dense_layer_seq.md
# dense_layer_seq

Frame sequencer for the fixed-point dense layer. It accepts a start request, then issues exactly NUM_CYC read beats to the shared input and weight buffers. It drives the dense layer's `vld_in` aligned to the buffer read latency, waits for the layer's `vld_out`, and presents the captured result downstream with a valid/ready handshake. It sits between the layer-level control FSM and one dense layer instance.

## Interface
- NUM_CYC, 512: beats (input vectors) per frame; must match the dense layer's NUM_CYC.
- MEM_LAT, 1: read latency in cycles of the input and weight buffers (range 0..4).
- TIMEOUT, 64: maximum cycles spent in WAIT before abort (watchdog builds only).
- AW, $clog2(NUM_CYC): buffer address width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  frame request; taken when `start && start_rdy`.
- start_rdy  out  1  high only in IDLE.
- src_vld  in  1  the input buffer holds the next beat's data.
- rd_en  out  1  buffer read strobe (combinational).
- rd_addr  out  AW  beat index for the input and weight buffers (registered).
- dl_vld_in  out  1  to the dense layer `vld_in`; `rd_en` delayed by MEM_LAT registers.
- dl_rst  out  1  to the dense layer `rst`.
- dl_vld_out  in  1  from the dense layer `vld_out`.
- cap_en  out  1  load enable for the external result holding register.
- res_valid  out  1  the held result is valid.
- res_ready  in  1  downstream accepts the result.
- busy  out  1  state != IDLE.
- err  out  2  sticky flags: [0] spurious `dl_vld_out`, [1] timeout.
- frames_done  out  16  count of completed frames; wraps at 2^16.

## Operation
The block is a five-state FSM:
- IDLE → ISSUE on an accepted start. `beat` clears to 0.
- ISSUE:
  - `rd_en = src_vld`; `rd_addr = beat`.
  - Each cycle with `rd_en` high, `beat` increments.
  - Gaps in `src_vld` are legal; the dense layer counts only `vld_in`.
  - The beat issued with `beat == NUM_CYC-1` moves the FSM to FLUSH; `beat` wraps to 0.
- FLUSH: stays MEM_LAT cycles (0 means it passes through in 1 cycle), then moves to WAIT.
- WAIT:
  - On `dl_vld_out`: `cap_en = 1` that same cycle, and the next state is HOLD.
  - A watchdog counts cycles in WAIT.
- HOLD:
  - `res_valid = 1` until `res_ready` is sampled high.
  - On acceptance: return to IDLE, increment `frames_done`, deassert `res_valid` on the next edge.
- Spurious pulse: `dl_vld_out` outside WAIT sets `err[0]`. It is otherwise ignored and does not assert `cap_en`.
- Start while busy: a start outside IDLE is not accepted, because `start_rdy` is low.
- `err` bits clear only on rst.
- `dl_rst = rst | abort_pulse`. This keeps the dense layer's internal beat counter aligned with `beat`.

## Timing
- Reset values:
  - state IDLE, `start_rdy` 1.
  - `rd_en`, `rd_addr`, `dl_vld_in`, `cap_en`, `res_valid`, `busy`, `err`, `frames_done`: all 0.
  - `dl_rst` is 1 while rst is high.
- Start to first read: start is accepted at edge N, so `rd_en` can be high from cycle N+1.
- Read-valid alignment: `dl_vld_in` is high exactly MEM_LAT cycles after each `rd_en`. Exactly NUM_CYC `dl_vld_in` pulses occur per frame.
- End-to-end latency: with no `src_vld` gaps and `res_ready` held high, start to `res_valid` is 1 + NUM_CYC + MEM_LAT + (dense latency) + 1 cycles.
- Handshake: `res_valid` never drops without `res_ready`. Ready/valid acceptance and a start in the same cycle as the return to IDLE are not merged; the start is taken on the following cycle.
- Reset mid-frame: the FSM returns to IDLE on the next edge, pending reads are discarded, `dl_vld_in` pipeline registers are cleared, and `dl_rst` is high that cycle.
- `rd_addr` holds its value during `src_vld` gaps.

## Configuration
- DENSE_SEQ_TIMEOUT_EN defined:
  - Counting: the WAIT counter is active.
  - Trigger: reaching TIMEOUT cycles without `dl_vld_out` triggers an abort.
  - Abort effects: set `err[1]`, pulse `dl_rst` for 1 cycle, go to IDLE, no `cap_en`, `frames_done` unchanged.
- Undefined: there is no counter, WAIT lasts indefinitely, `err[1]` is tied to 0, and `dl_rst = rst`.

## Test plan
All scenarios use NUM_CYC=4, MEM_LAT=1, and a dense layer model with 5-cycle latency.
- Start pulse, `src_vld` held high, `res_ready` high → `rd_addr` 0,1,2,3 on consecutive cycles; `dl_vld_in` shows 4 pulses, each 1 cycle behind `rd_en`; one `cap_en`; `res_valid` for 1 cycle; `frames_done`=1.
- `src_vld` pattern 1,0,0,1,1,0,1 → exactly 4 reads; `rd_addr` holds during the gaps; FLUSH is entered after the 4th read.
- `res_ready` held low for 10 cycles after `res_valid` → `res_valid` stays high and `start_rdy` stays 0. A start pulse in this window is ignored. When `res_ready` rises, the next edge gives IDLE.
- `dl_vld_out` pulsed during ISSUE → `err[0]`=1, no `cap_en`, and the frame completes normally.
- With DENSE_SEQ_TIMEOUT_EN and TIMEOUT=8, `dl_vld_out` suppressed → after 8 WAIT cycles: `err[1]`=1, a 1-cycle `dl_rst`, IDLE, `frames_done` unchanged.
- rst asserted in the cycle `rd_addr`=2 → all outputs return to their reset values. A new start then issues `rd_addr` 0..3 with no stray `dl_vld_in`.
